wb_clint: RTL and testbench



---
 rtl/clint_pkg.sv | 23 ++
 rtl/clint_tick_gen.sv | 28 ++
 rtl/wb_clint.sv | 108 ++++++++++
 tb/tb_wb_clint.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT register offsets, reset constants and the byte-lane merge helper.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// mtime prescaler: o_tick is high one cycle in every PRESCALE (every cycle when PRESCALE=1).
// Combinational tick from a registered counter; no backpressure.
module clint_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign o_tick = (cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_clint.sv
// Wishbone CLINT slave holding mtime, mtimecmp and msip; ack and read data one cycle after accept.
// Never stalls; dropping i_wb_cyc masks a pending ack but never undoes a committed write.
module wb_clint
  import clint_pkg::*;
#(
  parameter int PRESCALE   = 1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [31:0]           i_wb_data,
  input  logic [3:0]            i_wb_sel,
  output logic                  o_wb_ack,
  output logic                  o_wb_stall,
  output logic [31:0]           o_wb_data,
  output logic                  o_timer_interrupt,
  output logic                  o_software_interrupt
);

  logic tick;

  clint_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  logic                  accept;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  addr_lsb_unused;
  logic                  hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;

  assign accept          = i_wb_cyc & i_wb_stb;
  assign wr              = accept & i_wb_we;
  assign word_addr       = {i_wb_addr[ADDR_WIDTH-1:2], 2'b00};
  assign addr_lsb_unused = ^i_wb_addr[1:0];

  assign hit_msip    = (word_addr == ADDR_WIDTH'(CLINT_MSIP));
  assign hit_cmp_lo  = (word_addr == ADDR_WIDTH'(CLINT_MTIMECMP_LO));
  assign hit_cmp_hi  = (word_addr == ADDR_WIDTH'(CLINT_MTIMECMP_HI));
  assign hit_time_lo = (word_addr == ADDR_WIDTH'(CLINT_MTIME_LO));
  assign hit_time_hi = (word_addr == ADDR_WIDTH'(CLINT_MTIME_HI));

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        ack_q;
  logic        timer_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (hit_msip)    rd_mux = {31'd0, msip};
    if (hit_cmp_lo)  rd_mux = mtimecmp[31:0];
    if (hit_cmp_hi)  rd_mux = mtimecmp[63:32];
    if (hit_time_lo) rd_mux = mtime[31:0];
    if (hit_time_hi) rd_mux = mtime[63:32];
  end

  // A write to either half suppresses that cycle's tick for the whole 64-bit counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime <= '0;
    end else if (wr && hit_time_lo) begin
      mtime[31:0] <= byte_merge(mtime[31:0], i_wb_data, i_wb_sel);
    end else if (wr && hit_time_hi) begin
      mtime[63:32] <= byte_merge(mtime[63:32], i_wb_data, i_wb_sel);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtimecmp <= CLINT_MTIMECMP_RESET;
      msip     <= 1'b0;
    end else begin
      if (wr && hit_cmp_lo) mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], i_wb_data, i_wb_sel);
      if (wr && hit_cmp_hi) mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], i_wb_data, i_wb_sel);
      if (wr && hit_msip && i_wb_sel[0]) msip <= i_wb_data[0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      timer_q <= 1'b0;
    end else begin
      ack_q   <= accept;
      rdata_q <= accept ? rd_mux : 32'd0;
      timer_q <= (mtime >= mtimecmp);
    end
  end

  assign o_wb_ack             = ack_q & i_wb_cyc;
  assign o_wb_stall           = 1'b0;
  assign o_wb_data            = rdata_q;
  assign o_timer_interrupt    = timer_q;
  assign o_software_interrupt = msip;

endmodule

// File: tb/tb_wb_clint.sv
// Directed bench for wb_clint: one instance at PRESCALE=1, one at PRESCALE=4, sharing clock, reset and bus.
module tb_wb_clint;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb1 = 1'b0, stb4 = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;

  logic        ack1, stall1, tmr1, swi1;
  logic        ack4, stall4, tmr4, swi4;
  logic [31:0] rd1, rd4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_clint #(.PRESCALE(1), .ADDR_WIDTH(16)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb1), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_ack(ack1), .o_wb_stall(stall1), .o_wb_data(rd1),
    .o_timer_interrupt(tmr1), .o_software_interrupt(swi1)
  );

  wb_clint #(.PRESCALE(4), .ADDR_WIDTH(16)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb4), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_ack(ack4), .o_wb_stall(stall4), .o_wb_data(rd4),
    .o_timer_interrupt(tmr4), .o_software_interrupt(swi4)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc = 1'b0; stb1 = 1'b0; stb4 = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Single access with an idle cycle afterwards; samples ack before and 1 cycle after the accept edge.
  task automatic bus(input bit d4, input bit w, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdata, output logic ack_early,
                     output logic ack_late, output logic swi_now);
    @(negedge clk);
    cyc = 1'b1; we = w; addr = a; wdata = d; sel = s;
    if (d4) stb4 = 1'b1; else stb1 = 1'b1;
    #1 ack_early = d4 ? ack4 : ack1;
    @(posedge clk);
    #1;
    stb1 = 1'b0; stb4 = 1'b0; we = 1'b0;
    ack_late = d4 ? ack4 : ack1;
    rdata    = d4 ? rd4 : rd1;
    swi_now  = d4 ? swi4 : swi1;
    @(negedge clk);
    cyc = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r; logic ae, al, sw;
    do_reset();
    #1;
    checks++;
    if ({ack1, rd1, tmr1, swi1, stall1} !== 36'd0) begin
      errors++; $display("FAIL reset_outputs1 got ack=%b data=%h tmr=%b swi=%b stall=%b want all 0",
                         ack1, rd1, tmr1, swi1, stall1);
    end
    checks++;
    if ({ack4, rd4, tmr4, swi4} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs4 got ack=%b data=%h tmr=%b swi=%b want all 0", ack4, rd4, tmr4, swi4);
    end
    bus(1'b0, 1'b0, 16'h4000, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'hFFFF_FFFF || ae !== 1'b0 || al !== 1'b1) begin
      errors++; $display("FAIL reset_cmp_lo got data=%h ack_pre=%b ack=%b want ffffffff 0 1", r, ae, al);
    end
    bus(1'b0, 1'b0, 16'h4004, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'hFFFF_FFFF || ae !== 1'b0 || al !== 1'b1) begin
      errors++; $display("FAIL reset_cmp_hi got data=%h ack_pre=%b ack=%b want ffffffff 0 1", r, ae, al);
    end
    checks++;
    if (tmr1 !== 1'b0) begin
      errors++; $display("FAIL reset_timer_irq got %b want 0", tmr1);
    end
  endtask

  task automatic test_mtime_count();
    logic [31:0] v[4]; logic acks;
    acks = 1'b1;
    @(negedge clk);
    cyc = 1'b1; stb1 = 1'b1; we = 1'b0; addr = 16'hBFF8; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      v[i] = rd1;
      acks = acks & ack1;
    end
    cyc = 1'b0; stb1 = 1'b0;
    checks++;
    if (acks !== 1'b1) begin
      errors++; $display("FAIL b2b_acks got %b want 1", acks);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (v[i+1] - v[i] !== 32'd1) begin
        errors++; $display("FAIL mtime_step%0d got %h then %h want +1", i, v[i], v[i+1]);
      end
    end
  endtask

  task automatic test_carry_and_bytes();
    logic [31:0] r; logic ae, al, sw;
    bus(1'b0, 1'b1, 16'hBFFC, 32'h0, 4'hF, r, ae, al, sw);
    bus(1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, r, ae, al, sw);
    bus(1'b0, 1'b0, 16'hBFF8, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL carry_lo got %h want 00000000", r);
    end
    bus(1'b0, 1'b0, 16'hBFFC, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'h1) begin
      errors++; $display("FAIL carry_hi got %h want 00000001", r);
    end
    bus(1'b0, 1'b1, 16'h4000, 32'h0000_AB00, 4'b0010, r, ae, al, sw);
    bus(1'b0, 1'b0, 16'h4000, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'hFFFF_ABFF) begin
      errors++; $display("FAIL byte_write got %h want ffffabff", r);
    end
  endtask

  task automatic test_timer();
    logic early;
    early = 1'b0;
    do_reset();
    cyc = 1'b1; stb4 = 1'b1; we = 1'b1; addr = 16'h4004; wdata = 32'd0; sel = 4'hF;
    @(posedge clk); #1;
    addr = 16'h4000; wdata = 32'd20;
    @(posedge clk); #1;
    cyc = 1'b0; stb4 = 1'b0; we = 1'b0;
    // mtime reaches 20 on the 80th edge after reset release; the irq follows one edge later.
    for (int i = 0; i < 78; i++) begin
      @(posedge clk); #1;
      early = early | tmr4;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL timer_early got irq=1 before mtime reached 20 want 0");
    end
    @(posedge clk); #1;
    checks++;
    if (tmr4 !== 1'b1) begin
      errors++; $display("FAIL timer_rise got %b want 1", tmr4);
    end
    cyc = 1'b1; stb4 = 1'b1; we = 1'b1; addr = 16'h4004; wdata = 32'd1; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb4 = 1'b0; we = 1'b0;
    checks++;
    if (tmr4 !== 1'b1) begin
      errors++; $display("FAIL timer_hold got %b want 1", tmr4);
    end
    @(posedge clk); #1;
    checks++;
    if (tmr4 !== 1'b0) begin
      errors++; $display("FAIL timer_drop got %b want 0", tmr4);
    end
  endtask

  task automatic test_software();
    logic [31:0] r; logic ae, al, sw;
    bus(1'b0, 1'b1, 16'h0000, 32'h1, 4'hF, r, ae, al, sw);
    checks++;
    if (sw !== 1'b1) begin
      errors++; $display("FAIL msip_set got %b want 1", sw);
    end
    bus(1'b0, 1'b0, 16'h0000, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'h1) begin
      errors++; $display("FAIL msip_read got %h want 00000001", r);
    end
    bus(1'b0, 1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF, r, ae, al, sw);
    checks++;
    if (swi1 !== 1'b0) begin
      errors++; $display("FAIL msip_clear got %b want 0", swi1);
    end
    bus(1'b0, 1'b1, 16'h2000, 32'hDEAD_BEEF, 4'hF, r, ae, al, sw);
    checks++;
    if (al !== 1'b1) begin
      errors++; $display("FAIL unmapped_write_ack got %b want 1", al);
    end
    bus(1'b0, 1'b0, 16'h2000, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'h0 || al !== 1'b1) begin
      errors++; $display("FAIL unmapped_read got data=%h ack=%b want 00000000 1", r, al);
    end
  endtask

  task automatic test_collision_cancel();
    logic [31:0] l0, l1, h;
    @(negedge clk);
    cyc = 1'b1; stb1 = 1'b1; we = 1'b0; addr = 16'hBFF8; sel = 4'hF;
    @(posedge clk); #1;
    l0 = rd1;
    we = 1'b1; addr = 16'hBFFC; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    we = 1'b0; addr = 16'hBFF8;
    @(posedge clk); #1;
    l1 = rd1;
    addr = 16'hBFFC;
    @(posedge clk); #1;
    h = rd1;
    cyc = 1'b0; stb1 = 1'b0;
    checks++;
    if (l1 - l0 !== 32'd1) begin
      errors++; $display("FAIL collision_lo got %h then %h want +1 (no tick on write edge)", l0, l1);
    end
    checks++;
    if (h !== 32'h1234_5678) begin
      errors++; $display("FAIL collision_hi got %h want 12345678", h);
    end
    @(negedge clk);
    cyc = 1'b1; stb1 = 1'b1; we = 1'b1; addr = 16'h0000; wdata = 32'h1; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb1 = 1'b0; we = 1'b0;
    #1;
    checks++;
    if (ack1 !== 1'b0 || swi1 !== 1'b1) begin
      errors++; $display("FAIL cancel_ack got ack=%b swi=%b want 0 1", ack1, swi1);
    end
    @(posedge clk); #1;
    checks++;
    if (ack1 !== 1'b0) begin
      errors++; $display("FAIL cancel_late_ack got %b want 0", ack1);
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] r; logic ae, al, sw, stray;
    stray = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb1 = 1'b1; we = 1'b0; addr = 16'h4000; sel = 4'hF;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (ack1 !== 1'b1) begin
      errors++; $display("FAIL burst_ack got %b want 1", ack1);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ack1, rd1, tmr1, swi1} !== 35'd0) begin
      errors++; $display("FAIL midreset_outputs got ack=%b data=%h tmr=%b swi=%b want all 0", ack1, rd1, tmr1, swi1);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      stray = stray | ack1;
    end
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb1 = 1'b0;
    @(posedge clk); #1;
    stray = stray | ack1;
    checks++;
    if (stray !== 1'b0) begin
      errors++; $display("FAIL stray_ack got ack=1 after reset want 0");
    end
    bus(1'b0, 1'b0, 16'h4000, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL postreset_cmp got %h want ffffffff", r);
    end
    bus(1'b0, 1'b0, 16'hBFFC, 32'h0, 4'hF, r, ae, al, sw);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL postreset_mtime_hi got %h want 00000000", r);
    end
  endtask

  initial begin
    test_reset();
    test_mtime_count();
    test_carry_and_bytes();
    test_timer();
    test_software();
    test_collision_cancel();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
